// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP tile pixel pipeline.
// Holds screen geometry, default table bases and the fetch phase encoding.
package vdp_pkg;

    localparam int TILE_W   = 8;
    localparam int TILE_H   = 8;
    localparam int COLS     = 32;
    localparam int ROWS     = 24;
    localparam int ACTIVE_W = 256;
    localparam int ACTIVE_H = 192;

    localparam logic [13:0] NAME_BASE_DEFAULT = 14'h0000;
    localparam logic [13:0] PAT_BASE_DEFAULT  = 14'h0800;
    localparam logic [13:0] COL_BASE_DEFAULT  = 14'h1000;

    localparam logic [7:0] RGB8_BLACK = 8'h00;

    // Position inside an 8-clock tile slot, taken straight from hPos[2:0].
    typedef enum logic [2:0] {
        PH_NAME       = 3'd0,
        PH_PATTERN    = 3'd1,
        PH_FG         = 3'd2,
        PH_BG         = 3'd3,
        PH_BG_CAPTURE = 3'd4,
        PH_IDLE5      = 3'd5,
        PH_IDLE6      = 3'd6,
        PH_LOAD       = 3'd7
    } fetch_phase_e;

    typedef struct packed {
        logic [7:0] name;
        logic [7:0] pattern;
        logic [7:0] fg;
        logic [7:0] bg;
    } tile_fetch_t;

    // Table bases and offsets add modulo the 16 KiB VRAM space.
    function automatic logic [13:0] vramOffset(input logic [13:0] base,
                                               input logic [13:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/vdp_tile_renderer_shifter.sv
// Per-pixel output stage: pattern shift register, colour pair latch and
// the registered foreground/background/blank pixel mux.
module tile_pixel_shifter
    import vdp_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] pattern_i,
    input  logic [7:0] fgIn_i,
    input  logic [7:0] bgIn_i,
    input  logic       display_i,
    output logic [7:0] rgb_o
);

    logic [7:0] shift_q, shift_d;
    logic [7:0] fg_q, fg_d;
    logic [7:0] bg_q, bg_d;
    logic [7:0] rgb_q, rgb_d;

    always_comb begin
        shift_d = {shift_q[6:0], 1'b0};
        fg_d    = fg_q;
        bg_d    = bg_q;
        if (load_i) begin
            shift_d = pattern_i;
            fg_d    = fgIn_i;
            bg_d    = bgIn_i;
        end
        // The pixel uses the pre-edge shift state, so a load and the last
        // pixel of the outgoing tile share the same clock.
        rgb_d = RGB8_BLACK;
        if (display_i) begin
            rgb_d = shift_q[7] ? fg_q : bg_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            rgb_q   <= RGB8_BLACK;
        end else begin
            shift_q <= shift_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/vdp_tile_renderer.sv
// Tile-mode pixel generator: fetches name/pattern/colour one tile ahead of
// the beam and emits one registered RRRGGGBB pixel per clock.
module vdp_tile_renderer
    import vdp_pkg::*;
#(
    parameter int unsigned H_TOTAL   = 320,
    parameter logic [13:0] NAME_BASE = NAME_BASE_DEFAULT,
    parameter logic [13:0] PAT_BASE  = PAT_BASE_DEFAULT,
    parameter logic [13:0] COL_BASE  = COL_BASE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [8:0]  hPos_i,
    input  logic [8:0]  vPos_i,
    input  logic        display_i,
    input  logic        hSyncIn_i,
    input  logic        vSyncIn_i,
    output logic [13:0] vramAddr_o,
    output logic        vramRead_o,
    input  logic [7:0]  vramData_i,
    output logic [7:0]  rgb_o,
    output logic        hSync_o,
    output logic        vSync_o
);

    localparam logic [8:0] LAST_SLOT_START = 9'(H_TOTAL - TILE_W);
    localparam logic [8:0] LOOKAHEAD_END   = 9'(ACTIVE_W - TILE_W);
    localparam logic [8:0] ACTIVE_LINES    = 9'(ACTIVE_H);

    fetch_phase_e phase;
    logic         inLastSlot;
    logic         inLookahead;
    logic         fetchEn;
    logic         loadTile;
    logic [8:0]   fetchLine;
    logic [4:0]   colNext;
    logic [4:0]   fetchRow;
    logic [2:0]   fetchLineInTile;

    tile_fetch_t  next_q, next_d;
    logic         hSync_q, vSync_q;

    // The last slot of each line pre-fetches tile 0 of the following line.
    always_comb begin
        phase           = fetch_phase_e'(hPos_i[2:0]);
        inLastSlot      = hPos_i >= LAST_SLOT_START;
        inLookahead     = hPos_i < LOOKAHEAD_END;
        fetchLine       = inLastSlot ? vPos_i + 9'd1 : vPos_i;
        colNext         = inLastSlot ? 5'd0 : hPos_i[7:3] + 5'd1;
        fetchRow        = fetchLine[7:3];
        fetchLineInTile = fetchLine[2:0];
        fetchEn         = (inLastSlot || inLookahead) && (fetchLine < ACTIVE_LINES);
        loadTile        = phase == PH_LOAD;
    end

    always_comb begin
        vramAddr_o = '0;
        vramRead_o = 1'b0;
        if (!reset_i && fetchEn) begin
            case (phase)
                PH_NAME: begin
                    vramAddr_o = vramOffset(NAME_BASE, {4'b0, fetchRow, colNext});
                    vramRead_o = 1'b1;
                end
                PH_PATTERN: begin
                    vramAddr_o = vramOffset(PAT_BASE, {3'b0, vramData_i, fetchLineInTile});
                    vramRead_o = 1'b1;
                end
                PH_FG: begin
                    vramAddr_o = vramOffset(COL_BASE, {5'b0, next_q.name, 1'b0});
                    vramRead_o = 1'b1;
                end
                PH_BG: begin
                    vramAddr_o = vramOffset(COL_BASE, {5'b0, next_q.name, 1'b1});
                    vramRead_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Each byte arrives one clock after its strobe, so captures trail reads by one phase.
    always_comb begin
        next_d = next_q;
        if (fetchEn) begin
            case (phase)
                PH_PATTERN:    next_d.name    = vramData_i;
                PH_FG:         next_d.pattern = vramData_i;
                PH_BG:         next_d.fg      = vramData_i;
                PH_BG_CAPTURE: next_d.bg      = vramData_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            next_q  <= '0;
            hSync_q <= 1'b0;
            vSync_q <= 1'b0;
        end else begin
            next_q  <= next_d;
            hSync_q <= hSyncIn_i;
            vSync_q <= vSyncIn_i;
        end
    end

    tile_pixel_shifter pixelStage (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (loadTile),
        .pattern_i (next_q.pattern),
        .fgIn_i    (next_q.fg),
        .bgIn_i    (next_q.bg),
        .display_i (display_i),
        .rgb_o     (rgb_o)
    );

    assign hSync_o = hSync_q;
    assign vSync_o = vSync_q;

endmodule

// File: tb/tb_vdp_tile_renderer.sv
// Directed bench for vdp_tile_renderer: a VRAM model feeds the DUT and a
// screen-level reference model checks pixels, syncs and fetches every clock.
module tb_vdp_tile_renderer;

    localparam int          H_TOT  = 280;
    localparam logic [13:0] NAME_B = 14'h0400;
    localparam logic [13:0] PAT_B  = 14'h3A00;
    localparam logic [13:0] COL_B  = 14'h3F00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  hPos = '0;
    logic [8:0]  vPos = '0;
    logic        display = 1'b0;
    logic        hSyncIn = 1'b0;
    logic        vSyncIn = 1'b0;
    logic [13:0] vramAddr;
    logic        vramRead;
    logic [7:0]  vramData = '0;
    logic [7:0]  rgb;
    logic        hSync, vSync;

    logic [7:0]  mem [16384];
    logic [7:0]  rgbLog [H_TOT];
    logic [13:0] addrLog [H_TOT];
    logic        readLog [H_TOT];

    int checks = 0;
    int errors = 0;

    bit tbActive = 1'b0;
    int curH = 0, curV = 0, prevH = 0, prevV = 0;
    bit curRst = 1'b1, prevRst = 1'b1;
    bit curPixChk = 1'b0, prevPixChk = 1'b0, curFchk = 1'b0;
    bit curHs = 1'b0, curVs = 1'b0, prevHs = 1'b0, prevVs = 1'b0;

    vdp_tile_renderer #(
        .H_TOTAL   (H_TOT),
        .NAME_BASE (NAME_B),
        .PAT_BASE  (PAT_B),
        .COL_BASE  (COL_B)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .hPos_i     (hPos),
        .vPos_i     (vPos),
        .display_i  (display),
        .hSyncIn_i  (hSyncIn),
        .vSyncIn_i  (vSyncIn),
        .vramAddr_o (vramAddr),
        .vramRead_o (vramRead),
        .vramData_i (vramData),
        .rgb_o      (rgb),
        .hSync_o    (hSync),
        .vSync_o    (vSync)
    );

    always #5 clk = ~clk;

    // Synchronous VRAM: data for a strobed address is valid the next clock;
    // unstrobed cycles return a junk byte so mistimed captures show up.
    always @(posedge clk) begin
        vramData <= vramRead ? mem[vramAddr] : 8'h5A;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Screen-level rule: colour of the tile bit at (h, v), black outside 256x192.
    function automatic logic [7:0] expPix(input int h, input int v);
        int name, pat, bitv;
        if (h >= 256 || v >= 192) return 8'h00;
        name = int'(mem[(int'(NAME_B) + (v / 8) * 32 + h / 8) % 16384]);
        pat  = int'(mem[(int'(PAT_B) + name * 8 + v % 8) % 16384]);
        bitv = (pat >> (7 - h % 8)) & 1;
        return mem[(int'(COL_B) + 2 * name + (bitv != 0 ? 0 : 1)) % 16384];
    endfunction

    function automatic void expFetch(input int h, input int v, output bit rd, output int addr);
        int col, fl, name;
        bit en;
        rd = 1'b0;
        addr = 0;
        en = 1'b1;
        col = 0;
        fl = v;
        if (h >= H_TOT - 8) begin
            fl = (v + 1) % 512;
        end else if (h < 248) begin
            col = h / 8 + 1;
        end else begin
            en = 1'b0;
        end
        if (fl >= 192 || h % 8 > 3) en = 1'b0;
        if (!en) return;
        rd = 1'b1;
        name = int'(mem[(int'(NAME_B) + (fl / 8) * 32 + col) % 16384]);
        case (h % 8)
            0: addr = (int'(NAME_B) + (fl / 8) * 32 + col) % 16384;
            1: addr = (int'(PAT_B) + name * 8 + fl % 8) % 16384;
            2: addr = (int'(COL_B) + 2 * name) % 16384;
            default: addr = (int'(COL_B) + 2 * name + 1) % 16384;
        endcase
    endfunction

    // Single compare process: fetch outputs against the current beam
    // position, pixel and syncs against the previous one.
    always @(negedge clk) begin
        bit er;
        int ea;
        if (tbActive) begin
            if (reset) begin
                checkOutput("rstRgb", int'(rgb), 0);
                checkOutput("rstHSync", int'(hSync), 0);
                checkOutput("rstVSync", int'(vSync), 0);
                checkOutput("rstRead", int'(vramRead), 0);
                checkOutput("rstAddr", int'(vramAddr), 0);
            end else begin
                if (curFchk) begin
                    expFetch(curH, curV, er, ea);
                    checkOutput($sformatf("read h%0d v%0d", curH, curV), int'(vramRead), int'(er));
                    if (er) checkOutput($sformatf("addr h%0d v%0d", curH, curV), int'(vramAddr), ea);
                end
                if (prevRst) begin
                    checkOutput("postRstRgb", int'(rgb), 0);
                    checkOutput("postRstHSync", int'(hSync), 0);
                    checkOutput("postRstVSync", int'(vSync), 0);
                end else begin
                    checkOutput($sformatf("hSync h%0d", prevH), int'(hSync), int'(prevHs));
                    checkOutput($sformatf("vSync v%0d", prevV), int'(vSync), int'(prevVs));
                    if (prevPixChk)
                        checkOutput($sformatf("rgb h%0d v%0d", prevH, prevV), int'(rgb),
                                    int'(expPix(prevH, prevV)));
                end
            end
            rgbLog[prevH]  = rgb;
            readLog[curH]  = vramRead;
            addrLog[curH]  = vramAddr;
            prevH      = curH;
            prevV      = curV;
            prevRst    = curRst;
            prevPixChk = curPixChk;
            prevHs     = curHs;
            prevVs     = curVs;
        end
    end

    task automatic applyStimulus(input int h, input int v, input bit rst, input bit pixChk,
                                 input bit fChk);
        @(posedge clk);
        #1;
        hPos      = 9'(h);
        vPos      = 9'(v);
        display   = (h < 256) && (v < 192);
        hSyncIn   = (h >= 260) && (h < 268);
        vSyncIn   = ((v >= 192) && (v < 195)) || (v == 511);
        reset     = rst;
        curH      = h;
        curV      = v;
        curRst    = rst;
        curPixChk = pixChk;
        curFchk   = fChk;
        curHs     = hSyncIn;
        curVs     = vSyncIn;
        tbActive  = 1'b1;
    endtask

    // Reset is held for hPos in [rstFrom, rstTo); fetch checks skip such lines.
    task automatic runLine(input int v, input bit pixChk, input int rstFrom, input int rstTo);
        for (int h = 0; h < H_TOT; h++)
            applyStimulus(h, v, (h >= rstFrom) && (h < rstTo), pixChk, rstTo == 0);
    endtask

    initial begin
        int reads;
        logic [7:0] tile0 [8];

        for (int i = 0; i < 16384; i++)
            mem[i] = 8'((i * 73) ^ (i >> 5) ^ 8'h96);
        mem[14'h0400] = 8'h41;
        mem[14'h3C08] = 8'hA5;
        mem[14'h3F82] = 8'hE0;
        mem[14'h3F83] = 8'h03;
        // Name 0xC8 pushes both pattern and colour addresses past 14'h3FFF.
        mem[14'h0401] = 8'hC8;
        mem[14'h0040] = 8'h0F;
        mem[14'h0090] = 8'h11;
        mem[14'h0091] = 8'h22;
        mem[14'h0420] = 8'h07;
        mem[14'h3A38] = 8'h80;
        mem[14'h3F0E] = 8'h1C;
        mem[14'h3F0F] = 8'hFF;
        mem[14'h0423] = 8'h12;

        tile0 = '{8'hE0, 8'h03, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'h03, 8'hE0};
        checkOutput("modelPin h0", int'(expPix(0, 0)), 8'hE0);
        checkOutput("modelPin h1", int'(expPix(1, 0)), 8'h03);
        checkOutput("modelPin h12", int'(expPix(12, 0)), 8'h11);
        checkOutput("modelPin blank", int'(expPix(300, 5)), 8'h00);

        $display("[TB] reset held for a full line, then primer line 511");
        runLine(510, 1'b0, 0, H_TOT);
        // vPos 511 makes fetchLine wrap to 0, so tile 0 of line 0 is fetched here.
        runLine(511, 1'b1, 0, 0);

        runLine(0, 1'b1, 0, 0);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("tile0 px%0d", i), int'(rgbLog[i]), int'(tile0[i]));
        for (int i = 8; i < 16; i++)
            checkOutput($sformatf("wrapTile px%0d", i), int'(rgbLog[i]), i < 12 ? 8'h22 : 8'h11);
        checkOutput("wrapPatAddr", int'(addrLog[1]), 14'h0040);
        checkOutput("wrapFgAddr", int'(addrLog[2]), 14'h0090);
        checkOutput("wrapBgAddr", int'(addrLog[3]), 14'h0091);

        for (int v = 1; v < 10; v++) begin
            runLine(v, 1'b1, 0, 0);
            if (v == 7) begin
                checkOutput("lineWrapAddr", int'(addrLog[H_TOT - 8]), 14'h0420);
                checkOutput("lineWrapRead", int'(readLog[H_TOT - 8]), 1);
            end
            if (v == 8) begin
                checkOutput("line8 px0", int'(rgbLog[0]), 8'h1C);
                checkOutput("line8 px1", int'(rgbLog[1]), 8'hFF);
            end
            if (v == 9) begin
                checkOutput("fetchNameAddr", int'(addrLog[16]), 14'h0423);
                checkOutput("fetchPatAddr", int'(addrLog[17]), 14'h3A91);
                checkOutput("fetchFgAddr", int'(addrLog[18]), 14'h3F24);
                checkOutput("fetchBgAddr", int'(addrLog[19]), 14'h3F25);
                checkOutput("fetchRead15", int'(readLog[15]), 0);
                for (int h = 16; h < 24; h++)
                    checkOutput($sformatf("fetchRead%0d", h), int'(readLog[h]), h < 20 ? 1 : 0);
                checkOutput("slot31Read", int'(readLog[250]), 0);
            end
        end

        $display("[TB] bottom border lines");
        runLine(189, 1'b0, 0, 0);
        for (int v = 190; v < 194; v++) begin
            runLine(v, 1'b1, 0, 0);
            if (v == 192) begin
                reads = 0;
                for (int h = 0; h < H_TOT; h++) reads += int'(readLog[h]);
                checkOutput("noReadsLine192", reads, 0);
                checkOutput("blankPx", int'(rgbLog[40]), 0);
            end
        end

        $display("[TB] mid-line reset at hPos 100");
        runLine(20, 1'b0, 100, 103);
        runLine(21, 1'b1, 0, 0);
        applyStimulus(0, 22, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 22, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
